// File: rtl/wb_ram_pkg.sv
// Shared types and helpers for the Wishbone RAM bank array: FSM states,
// status-word field layout and one-hot decode functions.
package wb_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    localparam int STATUS_CNT_LSB = 0;
    localparam int STATUS_CNT_W   = 16;
    localparam int STATUS_CYC_LSB = 24;
    localparam int STATUS_CYC_W   = 8;

    localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

    function automatic logic onehot_ok(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [2:0] onehot_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_ram_bank.sv
// One synchronous RAM bank with byte write enables and optional output register.
// WB_RAM_PARITY_EN adds one even-parity bit per byte and flags mismatches on read.
module wb_ram_bank #(
    parameter int ADDRWIDTH = 9,
    parameter int DATAWIDTH = 32,
    parameter int RD_LAT    = 1
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic                   oreg_en,
    input  logic [ADDRWIDTH-1:0]   adr,
    input  logic [DATAWIDTH/8-1:0] byte_en,
    input  logic [DATAWIDTH-1:0]   wdata,
    output logic [DATAWIDTH-1:0]   rdata,
    output logic                   perr
);

    localparam int NB = DATAWIDTH / 8;
`ifdef WB_RAM_PARITY_EN
    localparam int MW = DATAWIDTH + NB;
`else
    localparam int MW = DATAWIDTH;
`endif

    logic [MW-1:0] mem [0:(1<<ADDRWIDTH)-1];
    logic [MW-1:0] ram_q_reg;
    logic [MW-1:0] word_q;

    // Parity bit of lane b sits at DATAWIDTH+b and is written together with its byte.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (byte_en[b]) begin
                    mem[adr][b*8 +: 8] <= wdata[b*8 +: 8];
`ifdef WB_RAM_PARITY_EN
                    mem[adr][DATAWIDTH+b] <= ^wdata[b*8 +: 8];
`endif
                end
            end
        end
        if (rd_en) begin
            ram_q_reg <= mem[adr];
        end
    end

    if (RD_LAT == 2) begin : g_oreg
        logic [MW-1:0] out_q_reg;
        always_ff @(posedge clk) begin
            if (oreg_en) out_q_reg <= ram_q_reg;
        end
        assign word_q = out_q_reg;
    end else begin : g_direct
        logic oreg_unused;
        assign oreg_unused = oreg_en;
        assign word_q      = ram_q_reg;
    end

    assign rdata = word_q[DATAWIDTH-1:0];

`ifdef WB_RAM_PARITY_EN
    always_comb begin
        perr = 1'b0;
        for (int b = 0; b < NB; b++) begin
            perr = perr | (word_q[DATAWIDTH+b] ^ (^word_q[b*8 +: 8]));
        end
    end
`else
    assign perr = 1'b0;
`endif

endmodule

// File: rtl/wb_ram_bank_array.sv
// Wishbone slave fronting NUM_BANKS RAM banks selected by one-hot CYC, with a
// wait-state FSM, decode-error terminate and an error status word (WB_RAM_PARITY_EN optional).
module wb_ram_bank_array
    import wb_ram_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int ADDRWIDTH = 9,
    parameter int DATAWIDTH = 32,
    parameter int RD_LAT    = 1
) (
    input  logic                   WBs_CLK_i,
    input  logic                   WBs_RSTn_i,
    input  logic [ADDRWIDTH-1:0]   WBs_ADR_i,
    input  logic [NUM_BANKS-1:0]   WBs_CYC_i,
    input  logic [DATAWIDTH/8-1:0] WBs_BYTE_STB_i,
    input  logic                   WBs_WE_i,
    input  logic                   WBs_STB_i,
    input  logic [DATAWIDTH-1:0]   WBs_DAT_i,
    output logic [DATAWIDTH-1:0]   WBs_DAT_o,
    output logic                   WBs_ACK_o,
    output logic                   WBs_ERR_o,
    output logic [31:0]            WBs_RAM_STATUS_o,
    input  logic                   status_clr_i
);

    state_t               state_reg;
    logic                 ack_reg;
    logic                 err_reg;
    logic                 rd_resp_reg;
    logic [2:0]           sel_reg;
    logic [7:0]           cyc_reg;
    logic [DATAWIDTH-1:0] dat_hold_reg;
    logic [15:0]          err_cnt_reg;
    logic [7:0]           last_err_cyc_reg;

    logic [7:0]           cyc8;
    logic                 req, dec_ok, idle_req, wr_issue, rd_issue, oreg_en;
    logic                 par_fail, err_event;
    logic [DATAWIDTH-1:0] rd_data;
    logic [DATAWIDTH-1:0] bank_q [8];
    logic [7:0]           bank_perr;

    always_comb begin
        cyc8 = 8'd0;
        for (int i = 0; i < NUM_BANKS; i++) cyc8[i] = WBs_CYC_i[i];
    end

    assign req      = WBs_STB_i & (|WBs_CYC_i);
    assign dec_ok   = onehot_ok(cyc8);
    assign idle_req = (state_reg == ST_IDLE) & req;
    assign wr_issue = idle_req & dec_ok & WBs_WE_i;
    assign rd_issue = idle_req & dec_ok & ~WBs_WE_i;
    assign oreg_en  = (state_reg == ST_RD_WAIT);

    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_bank
        if (gi < NUM_BANKS) begin : g_inst
            wb_ram_bank #(
                .ADDRWIDTH (ADDRWIDTH),
                .DATAWIDTH (DATAWIDTH),
                .RD_LAT    (RD_LAT)
            ) u_bank (
                .clk     (WBs_CLK_i),
                .wr_en   (wr_issue & cyc8[gi]),
                .rd_en   (rd_issue & cyc8[gi]),
                .oreg_en (oreg_en),
                .adr     (WBs_ADR_i),
                .byte_en (WBs_BYTE_STB_i),
                .wdata   (WBs_DAT_i),
                .rdata   (bank_q[gi]),
                .perr    (bank_perr[gi])
            );
        end else begin : g_none
            assign bank_q[gi]    = '0;
            assign bank_perr[gi] = 1'b0;
        end
    end

    assign rd_data  = bank_q[sel_reg];
    // A parity mismatch turns the pending read ACK into an ERR during the response cycle.
    assign par_fail = rd_resp_reg & bank_perr[sel_reg];

    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) begin
            state_reg   <= ST_IDLE;
            ack_reg     <= 1'b0;
            err_reg     <= 1'b0;
            rd_resp_reg <= 1'b0;
            sel_reg     <= 3'd0;
            cyc_reg     <= 8'd0;
        end else begin
            ack_reg     <= 1'b0;
            err_reg     <= 1'b0;
            rd_resp_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        cyc_reg <= cyc8;
                        if (!dec_ok) begin
                            err_reg   <= 1'b1;
                            state_reg <= ST_RESP;
                        end else if (WBs_WE_i) begin
                            ack_reg   <= 1'b1;
                            state_reg <= ST_RESP;
                        end else begin
                            sel_reg <= onehot_idx(cyc8);
                            if (RD_LAT == 2) begin
                                state_reg <= ST_RD_WAIT;
                            end else begin
                                ack_reg     <= 1'b1;
                                rd_resp_reg <= 1'b1;
                                state_reg   <= ST_RESP;
                            end
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (!WBs_STB_i) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        ack_reg     <= 1'b1;
                        rd_resp_reg <= 1'b1;
                        state_reg   <= ST_RESP;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) begin
            dat_hold_reg <= '0;
        end else if (rd_resp_reg) begin
            dat_hold_reg <= rd_data;
        end
    end

    assign WBs_DAT_o = rd_resp_reg ? rd_data : dat_hold_reg;
    assign WBs_ACK_o = ack_reg & ~par_fail;
    assign WBs_ERR_o = err_reg | par_fail;

    assign err_event = (idle_req & ~dec_ok) | par_fail;

    // An error in the same cycle as a clear restarts the count at one.
    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) begin
            err_cnt_reg      <= 16'd0;
            last_err_cyc_reg <= 8'd0;
        end else if (err_event) begin
            last_err_cyc_reg <= par_fail ? cyc_reg : cyc8;
            if (status_clr_i)
                err_cnt_reg <= 16'd1;
            else if (err_cnt_reg != ERR_CNT_MAX)
                err_cnt_reg <= err_cnt_reg + 16'd1;
        end else if (status_clr_i) begin
            err_cnt_reg      <= 16'd0;
            last_err_cyc_reg <= 8'd0;
        end
    end

    always_comb begin
        WBs_RAM_STATUS_o = 32'd0;
        WBs_RAM_STATUS_o[STATUS_CYC_LSB +: STATUS_CYC_W] = last_err_cyc_reg;
        WBs_RAM_STATUS_o[STATUS_CNT_LSB +: STATUS_CNT_W] = err_cnt_reg;
    end

endmodule

// File: tb/tb_wb_ram_bank_array.sv
// Scoreboard bench for wb_ram_bank_array; override RD_LAT with -G to cover both latencies,
// define WB_RAM_PARITY_EN to switch the corrupted-read expectation.
module tb_wb_ram_bank_array #(parameter int RD_LAT = 1);

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [8:0]  adr   = '0;
    logic [3:0]  cyc   = '0;
    logic [3:0]  be    = '0;
    logic        we    = 1'b0;
    logic        stb   = 1'b0;
    logic        clr   = 1'b0;
    logic [31:0] dat_w = '0;
    logic [31:0] dat_r;
    logic [31:0] status;
    logic        ack, err;

    typedef struct {
        bit          is_err;
        bit          chk_data;
        logic [31:0] data;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   resp_cnt = 0;
    int   cyc_cnt  = 0;

    wb_ram_bank_array #(
        .NUM_BANKS (4),
        .ADDRWIDTH (9),
        .DATAWIDTH (32),
        .RD_LAT    (RD_LAT)
    ) dut (
        .WBs_CLK_i        (clk),
        .WBs_RSTn_i       (rst_n),
        .WBs_ADR_i        (adr),
        .WBs_CYC_i        (cyc),
        .WBs_BYTE_STB_i   (be),
        .WBs_WE_i         (we),
        .WBs_STB_i        (stb),
        .WBs_DAT_i        (dat_w),
        .WBs_DAT_o        (dat_r),
        .WBs_ACK_o        (ack),
        .WBs_ERR_o        (err),
        .WBs_RAM_STATUS_o (status),
        .status_clr_i     (clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (ack || err)) begin
                resp_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: ack=%0b err=%0b dat=%h, required no response", ack, err, dat_r);
                end else begin
                    e = sb.pop_front();
                    if (ack !== !e.is_err || err !== e.is_err || cyc_cnt != e.cyc ||
                        (e.chk_data && dat_r !== e.data)) begin
                        errors++;
                        $display("FAIL %s: got ack=%0b err=%0b dat=%h cycle=%0d, required ack=%0b err=%0b dat=%h cycle=%0d",
                                 e.name, ack, err, dat_r, cyc_cnt, !e.is_err, e.is_err, e.data, e.cyc);
                    end else begin
                        $display("PASS %s: ack=%0b err=%0b dat=%h cycle=%0d", e.name, ack, err, dat_r, cyc_cnt);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end else begin
            $display("PASS %s: %h", name, got);
        end
    endtask

    // Starts at posedge+1, pushes the expected response once the request is accepted,
    // then waits (bounded) for the termination and releases the bus.
    task automatic xfer(input string name, input logic [3:0] c, input logic w, input logic [8:0] a,
                        input logic [31:0] d, input logic [3:0] b, input bit exp_err, input bit chk,
                        input logic [31:0] exp_d, input int lat);
        exp_t e;
        int   n;
        cyc = c; we = w; adr = a; dat_w = d; be = b; stb = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        e.is_err = exp_err; e.chk_data = chk; e.data = exp_d; e.cyc = cyc_cnt + lat - 1; e.name = name;
        sb.push_back(e);
        n = 0;
        while (!(ack || err) && n < 6) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 6) begin
            errors++;
            $display("FAIL %s_timeout: no termination after %0d cycles, required one within %0d", name, n, lat);
        end
        @(posedge clk); #1;
        stb = 1'b0; cyc = '0; we = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_dat", dat_r, 32'd0);
        check("rst_status", status, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T2: full write and readback
        xfer("t2_wr", 4'b0100, 1'b1, 9'h1A5, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 32'h0, 1);
        xfer("t2_rd", 4'b0100, 1'b0, 9'h1A5, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFEF00D, RD_LAT);

        // T3: single byte lane, read data must hold across the write
        xfer("t3_wr", 4'b0100, 1'b1, 9'h1A5, 32'h0000AB00, 4'b0010, 1'b0, 1'b0, 32'h0, 1);
        check("t3_dat_hold", dat_r, 32'hCAFEF00D);
        xfer("t3_rd", 4'b0100, 1'b0, 9'h1A5, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFEAB0D, RD_LAT);

        // T4: multi-hot decode error must not touch either bank
        xfer("t4_wr_b0", 4'b0001, 1'b1, 9'h010, 32'h11111111, 4'hF, 1'b0, 1'b0, 32'h0, 1);
        xfer("t4_wr_b1", 4'b0010, 1'b1, 9'h010, 32'h22222222, 4'hF, 1'b0, 1'b0, 32'h0, 1);
        xfer("t4_err", 4'b0011, 1'b1, 9'h010, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0, 1);
        check("t4_status", status, 32'h0300_0001);
        xfer("t4_rd_b0", 4'b0001, 1'b0, 9'h010, 32'h0, 4'h0, 1'b0, 1'b1, 32'h11111111, RD_LAT);
        xfer("t4_rd_b1", 4'b0010, 1'b0, 9'h010, 32'h0, 4'h0, 1'b0, 1'b1, 32'h22222222, RD_LAT);
        clr = 1'b1;
        xfer("t4_err_clr", 4'b1100, 1'b0, 9'h000, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1);
        check("t4_status_clr_err", status, 32'h0C00_0001);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("t4_status_clr", status, 32'h0);
        xfer("t4_err2", 4'b0110, 1'b0, 9'h000, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1);
        check("t4_status2", status, 32'h0600_0001);

        // T1: reset in the middle of a read
        cyc = 4'b0100; adr = 9'h1A5; we = 1'b0; stb = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t1_ack", 32'(ack), 32'd0);
        check("t1_err", 32'(err), 32'd0);
        check("t1_status", status, 32'd0);
        check("t1_dat", dat_r, 32'd0);
        stb = 1'b0; cyc = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        xfer("t1_rd_after", 4'b0100, 1'b0, 9'h1A5, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFEAB0D, RD_LAT);

        // T5: strobe dropped one cycle after the read is accepted
        base = resp_cnt;
        cyc = 4'b0001; adr = 9'h010; we = 1'b0; stb = 1'b1;
        @(posedge clk); #1;
        if (RD_LAT == 1) begin
            exp_t e;
            e.is_err = 1'b0; e.chk_data = 1'b1; e.data = 32'h11111111; e.cyc = cyc_cnt; e.name = "t5_lat1_resp";
            sb.push_back(e);
        end
        stb = 1'b0; cyc = '0;
        repeat (4) @(posedge clk);
        #1;
        check("t5_abort_resp_count", resp_cnt - base, (RD_LAT == 1) ? 32'd1 : 32'd0);
        xfer("t5_rd_b0", 4'b0001, 1'b0, 9'h010, 32'h0, 4'h0, 1'b0, 1'b1, 32'h11111111, RD_LAT);

        // T6: flip stored bit 3 behind the bus
        dut.g_bank[2].g_inst.u_bank.mem[9'h1A5][3] = ~dut.g_bank[2].g_inst.u_bank.mem[9'h1A5][3];
`ifdef WB_RAM_PARITY_EN
        xfer("t6_parity_err", 4'b0100, 1'b0, 9'h1A5, 32'h0, 4'h0, 1'b1, 1'b1, 32'hCAFEAB05, RD_LAT);
        check("t6_status", status, 32'h0400_0001);
`else
        xfer("t6_no_parity", 4'b0100, 1'b0, 9'h1A5, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFEAB05, RD_LAT);
        check("t6_status", status, 32'h0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
